// File: rtl/serial_uart_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_pkg : state types and line constants for serial_uart_bridge   |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
package serial_pkg;

  localparam int   UART_DATA_BITS = 8;
  localparam logic LINE_IDLE      = 1'b1;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/serial_uart_bridge_byte_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | byte_fifo : first-word fall-through byte FIFO, register array        |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int              PTR_W       = $clog2(DEPTH);
  localparam logic [PTR_W:0]  DEPTH_COUNT = (PTR_W + 1)'(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == DEPTH_COUNT);
  assign empty    = (count == '0);
  assign pop_ok   = pop && !empty;
  // A pop in the same cycle frees the slot the push is about to use.
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_uart_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_uart_bridge : CPU byte handshake <-> 8N1 UART, FIFO per path  |
// | Revision           : 1.0                                             |
// +----------------------------------------------------------------------+
module serial_uart_bridge #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rx_in,
  output logic       uart_tx_out,
  output logic [7:0] cpu_data_out,
  output logic       cpu_valid_out,
  input  logic       cpu_rden_in,
  input  logic [7:0] cpu_data_in,
  input  logic       cpu_wren_in,
  output logic       cpu_ready_out,
  output logic       rx_overrun_out,
  output logic       frame_error_out
);

  import serial_pkg::*;

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

  logic rx_meta;
  logic rx_sync;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= LINE_IDLE;
      rx_sync <= LINE_IDLE;
    end else begin
      rx_meta <= uart_rx_in;
      rx_sync <= rx_meta;
    end
  end

  // ---------------- RX path ----------------
  rx_state_t        rx_state, rx_state_next;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_next;
  logic [2:0]       rx_bit, rx_bit_next;
  logic [7:0]       rx_shift, rx_shift_next;
  logic             rx_push;
  logic             rx_bad_stop;
  logic             rx_full;
  logic             rx_empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_next;
      rx_cnt   <= rx_cnt_next;
      rx_bit   <= rx_bit_next;
      rx_shift <= rx_shift_next;
    end
  end

  always_comb begin
    rx_state_next = rx_state;
    rx_cnt_next   = rx_cnt + 1'b1;
    rx_bit_next   = rx_bit;
    rx_shift_next = rx_shift;
    rx_push       = 1'b0;
    rx_bad_stop   = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_next = '0;
        // The detection cycle counts as the first cycle of the half-bit wait.
        if (rx_sync != LINE_IDLE) begin
          rx_state_next = RX_START;
          rx_cnt_next   = CNT_W'(1);
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_next   = '0;
          rx_bit_next   = '0;
          rx_state_next = (rx_sync == LINE_IDLE) ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_next   = '0;
          rx_shift_next = {rx_sync, rx_shift[7:1]};
          if (rx_bit == LAST_BIT) begin
            rx_state_next = RX_STOP;
          end else begin
            rx_bit_next = rx_bit + 1'b1;
          end
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_next   = '0;
          rx_state_next = RX_IDLE;
          if (rx_sync == LINE_IDLE) begin
            rx_push = 1'b1;
          end else begin
            rx_bad_stop = 1'b1;
          end
        end
      end
      default: begin
        rx_state_next = RX_IDLE;
        rx_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_overrun_out  <= 1'b0;
      frame_error_out <= 1'b0;
    end else begin
      if (rx_push && rx_full && !cpu_rden_in) begin
        rx_overrun_out <= 1'b1;
      end
      if (rx_bad_stop) begin
        frame_error_out <= 1'b1;
      end
    end
  end

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) rx_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (rx_push),
    .push_data(rx_shift),
    .pop      (cpu_rden_in),
    .pop_data (cpu_data_out),
    .full     (rx_full),
    .empty    (rx_empty)
  );

  assign cpu_valid_out = !rx_empty;

  // ---------------- TX path ----------------
  tx_state_t        tx_state, tx_state_next;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_next;
  logic [2:0]       tx_bit, tx_bit_next;
  logic [7:0]       tx_shift, tx_shift_next;
  logic             tx_line, tx_line_next;
  logic             tx_pop;
  logic             tx_full;
  logic             tx_empty;
  logic [7:0]       tx_head;

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) tx_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (cpu_wren_in),
    .push_data(cpu_data_in),
    .pop      (tx_pop),
    .pop_data (tx_head),
    .full     (tx_full),
    .empty    (tx_empty)
  );

  assign cpu_ready_out = !tx_full;
  assign uart_tx_out   = tx_line;

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= LINE_IDLE;
    end else begin
      tx_state <= tx_state_next;
      tx_cnt   <= tx_cnt_next;
      tx_bit   <= tx_bit_next;
      tx_shift <= tx_shift_next;
      tx_line  <= tx_line_next;
    end
  end

  always_comb begin
    tx_state_next = tx_state;
    tx_cnt_next   = tx_cnt + 1'b1;
    tx_bit_next   = tx_bit;
    tx_shift_next = tx_shift;
    tx_line_next  = tx_line;
    tx_pop        = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_next  = '0;
        tx_line_next = LINE_IDLE;
        if (!tx_empty) begin
          tx_pop        = 1'b1;
          tx_shift_next = tx_head;
          tx_bit_next   = '0;
          tx_state_next = TX_START;
          tx_line_next  = ~LINE_IDLE;
        end
      end
      TX_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_next   = '0;
          tx_state_next = TX_DATA;
          tx_line_next  = tx_shift[0];
        end
      end
      TX_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_next = '0;
          if (tx_bit == LAST_BIT) begin
            tx_state_next = TX_STOP;
            tx_line_next  = LINE_IDLE;
          end else begin
            tx_bit_next   = tx_bit + 1'b1;
            tx_shift_next = {1'b0, tx_shift[7:1]};
            tx_line_next  = tx_shift[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_next   = '0;
          tx_state_next = TX_IDLE;
        end
      end
      default: begin
        tx_state_next = TX_IDLE;
        tx_cnt_next   = '0;
        tx_line_next  = LINE_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_uart_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_serial_uart_bridge : randomized bench with a bit-level UART model |
// | Revision              : 1.0                                          |
// +----------------------------------------------------------------------+
module tb_serial_uart_bridge;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx_drive = 1'b1;
  logic       loopback = 1'b0;
  logic       uart_rx_in;
  logic       uart_tx_out;
  logic [7:0] cpu_data_out;
  logic       cpu_valid_out;
  logic       cpu_rden_in = 1'b0;
  logic [7:0] cpu_data_in = 8'h00;
  logic       cpu_wren_in = 1'b0;
  logic       cpu_ready_out;
  logic       rx_overrun_out;
  logic       frame_error_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  assign uart_rx_in = loopback ? uart_tx_out : rx_drive;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  serial_uart_bridge #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .uart_rx_in     (uart_rx_in),
    .uart_tx_out    (uart_tx_out),
    .cpu_data_out   (cpu_data_out),
    .cpu_valid_out  (cpu_valid_out),
    .cpu_rden_in    (cpu_rden_in),
    .cpu_data_in    (cpu_data_in),
    .cpu_wren_in    (cpu_wren_in),
    .cpu_ready_out  (cpu_ready_out),
    .rx_overrun_out (rx_overrun_out),
    .frame_error_out(frame_error_out)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic apply_reset();
    reset       = 1'b1;
    cpu_wren_in = 1'b0;
    cpu_rden_in = 1'b0;
    rx_drive    = 1'b1;
    loopback    = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  // Expected line level for bit k of an 8N1 frame (0 = start, 9 = stop).
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic write_tx(input logic [7:0] b);
    cpu_data_in = b;
    cpu_wren_in = 1'b1;
    step(1);
    cpu_wren_in = 1'b0;
  endtask

  task automatic send_rx_frame(input logic [7:0] b, input logic stop_bit, input int stop_len);
    rx_drive = 1'b0;
    step(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_drive = b[i];
      step(CPB);
    end
    rx_drive = stop_bit;
    step(stop_len);
    rx_drive = 1'b1;
    if (stop_len < CPB) step(CPB - stop_len);
  endtask

  // Reference UART receiver: finds the start edge, samples every bit mid-cell.
  task automatic capture_tx(output logic [7:0] b, output bit ok, output int start, input int budget);
    int n = 0;
    ok    = 1'b1;
    b     = 8'h00;
    start = 0;
    while (uart_tx_out !== 1'b0 && n < budget) begin
      step(1);
      n++;
    end
    if (uart_tx_out !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    start = cyc;
    step(CPB / 2);
    if (uart_tx_out !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(CPB);
      b[i] = uart_tx_out;
    end
    step(CPB);
    if (uart_tx_out !== 1'b1) ok = 1'b0;
  endtask

  task automatic pop_rx(output logic [7:0] b, output bit ok, input int budget);
    int n = 0;
    b = 8'h00;
    while (cpu_valid_out !== 1'b1 && n < budget) begin
      step(1);
      n++;
    end
    ok = (cpu_valid_out === 1'b1);
    if (!ok) return;
    b = cpu_data_out;
    cpu_rden_in = 1'b1;
    step(1);
    cpu_rden_in = 1'b0;
  endtask

  task automatic check_popped(input string name, input logic [7:0] want);
    logic [7:0] got;
    bit ok;
    pop_rx(got, ok, 3 * FRAME);
    checks++;
    if (!ok || got !== want) begin
      errors++;
      $display("FAIL %s got %h (valid seen %0d) want %h", name, got, ok, want);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (uart_tx_out !== 1'b1)     begin errors++; $display("FAIL reset_tx got %b want 1", uart_tx_out); end
    checks++; if (cpu_data_out !== 8'h00)   begin errors++; $display("FAIL reset_data got %h want 00", cpu_data_out); end
    checks++; if (cpu_valid_out !== 1'b0)   begin errors++; $display("FAIL reset_valid got %b want 0", cpu_valid_out); end
    checks++; if (cpu_ready_out !== 1'b1)   begin errors++; $display("FAIL reset_ready got %b want 1", cpu_ready_out); end
    checks++; if (rx_overrun_out !== 1'b0)  begin errors++; $display("FAIL reset_overrun got %b want 0", rx_overrun_out); end
    checks++; if (frame_error_out !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", frame_error_out); end
  endtask

  task automatic test_tx_single();
    logic [7:0] b = 8'hA5;
    bit bad;
    apply_reset();
    write_tx(b);
    checks++; if (uart_tx_out !== 1'b1) begin errors++; $display("FAIL tx_early got %b want 1", uart_tx_out); end
    step(1);
    for (int k = 0; k < 10; k++) begin
      bad = 1'b0;
      for (int c = 0; c < CPB; c++) begin
        if (uart_tx_out !== frame_bit(b, k)) bad = 1'b1;
        step(1);
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL tx_bit%0d got unstable/wrong level want %b", k, frame_bit(b, k));
      end
    end
  endtask

  task automatic test_loopback();
    logic [7:0] fixed [3];
    logic [7:0] q[$];
    apply_reset();
    loopback = 1'b1;
    fixed[0] = 8'h3C; fixed[1] = 8'hFF; fixed[2] = 8'h00;
    for (int i = 0; i < 3; i++) write_tx(fixed[i]);
    for (int i = 0; i < 3; i++) check_popped("loop_fixed", fixed[i]);
    for (int i = 0; i < DEPTH; i++) begin
      logic [7:0] r;
      r = 8'($urandom);
      q.push_back(r);
      write_tx(r);
    end
    while (q.size() > 0) check_popped("loop_rand", q.pop_front());
    checks++; if (rx_overrun_out !== 1'b0)  begin errors++; $display("FAIL loop_overrun got %b want 0", rx_overrun_out); end
    checks++; if (frame_error_out !== 1'b0) begin errors++; $display("FAIL loop_ferr got %b want 0", frame_error_out); end
  endtask

  task automatic test_rx_latency_random();
    logic [7:0] q[$];
    logic [7:0] b;
    int lat = 0;
    apply_reset();
    b = 8'($urandom);
    fork
      send_rx_frame(b, 1'b1, CPB);
      begin
        while (cpu_valid_out !== 1'b1 && lat < 2 * FRAME) begin
          step(1);
          lat++;
        end
      end
    join
    checks++;
    if (lat != 2 + CPB / 2 + 9 * CPB) begin
      errors++;
      $display("FAIL rx_latency got %0d want %0d", lat, 2 + CPB / 2 + 9 * CPB);
    end
    check_popped("rx_first", b);
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      q.push_back(b);
      send_rx_frame(b, 1'b1, CPB);
    end
    while (q.size() > 0) check_popped("rx_rand", q.pop_front());
  endtask

  task automatic test_overrun();
    apply_reset();
    for (int i = 1; i <= 4; i++) send_rx_frame(8'(i), 1'b1, CPB);
    checks++; if (rx_overrun_out !== 1'b0) begin errors++; $display("FAIL overrun_early got %b want 0", rx_overrun_out); end
    send_rx_frame(8'h05, 1'b1, CPB);
    checks++; if (rx_overrun_out !== 1'b1) begin errors++; $display("FAIL overrun_set got %b want 1", rx_overrun_out); end
    for (int i = 1; i <= 4; i++) check_popped("overrun_data", 8'(i));
    checks++; if (cpu_valid_out !== 1'b0) begin errors++; $display("FAIL overrun_extra got valid %b want 0", cpu_valid_out); end
  endtask

  // Fifth byte arrives on a full FIFO in the very cycle the CPU pops.
  task automatic test_full_push_pop();
    logic [7:0] q[$];
    logic [7:0] b;
    logic [7:0] head;
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      q.push_back(b);
      send_rx_frame(b, 1'b1, CPB);
    end
    b = 8'($urandom);
    head = 8'h00;
    fork
      send_rx_frame(b, 1'b1, CPB);
      begin
        step(1 + CPB / 2 + 9 * CPB);
        head = cpu_data_out;
        cpu_rden_in = 1'b1;
        step(1);
        cpu_rden_in = 1'b0;
      end
    join
    checks++; if (head !== q[0]) begin errors++; $display("FAIL pushpop_head got %h want %h", head, q[0]); end
    void'(q.pop_front());
    q.push_back(b);
    checks++; if (rx_overrun_out !== 1'b0) begin errors++; $display("FAIL pushpop_overrun got %b want 0", rx_overrun_out); end
    while (q.size() > 0) check_popped("pushpop_data", q.pop_front());
  endtask

  task automatic test_glitch_frame_error();
    apply_reset();
    rx_drive = 1'b0;
    step(4);
    rx_drive = 1'b1;
    step(3 * CPB);
    checks++; if (cpu_valid_out !== 1'b0)   begin errors++; $display("FAIL glitch_valid got %b want 0", cpu_valid_out); end
    checks++; if (frame_error_out !== 1'b0) begin errors++; $display("FAIL glitch_ferr got %b want 0", frame_error_out); end
    // Low stop bit held for 3/4 of a cell: covers the mid-bit sample cleanly.
    send_rx_frame(8'h55, 1'b0, 3 * CPB / 4);
    step(2 * CPB);
    checks++; if (cpu_valid_out !== 1'b0)   begin errors++; $display("FAIL ferr_valid got %b want 0", cpu_valid_out); end
    checks++; if (frame_error_out !== 1'b1) begin errors++; $display("FAIL ferr_flag got %b want 1", frame_error_out); end
    checks++; if (rx_overrun_out !== 1'b0)  begin errors++; $display("FAIL ferr_overrun got %b want 0", rx_overrun_out); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [6];
    logic [7:0] exp_q[$];
    logic [7:0] got [5];
    bit         oks [5];
    int         starts [5];
    logic       exp_ready;
    int         accepted = 0;
    logic [7:0] extra;
    bit         extra_ok;
    int         extra_start;
    apply_reset();
    foreach (bytes[i]) bytes[i] = 8'($urandom);
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          // The transmitter takes the first byte one edge after it lands.
          exp_ready = ((accepted - ((k >= 2) ? 1 : 0)) < DEPTH);
          checks++;
          if (cpu_ready_out !== exp_ready) begin
            errors++;
            $display("FAIL b2b_ready%0d got %b want %b", k, cpu_ready_out, exp_ready);
          end
          if (exp_ready) begin
            exp_q.push_back(bytes[k]);
            accepted++;
          end
          cpu_data_in = bytes[k];
          cpu_wren_in = 1'b1;
          step(1);
        end
        cpu_wren_in = 1'b0;
      end
      begin
        for (int f = 0; f < 5; f++) capture_tx(got[f], oks[f], starts[f], 3 * FRAME);
      end
    join
    for (int f = 0; f < 5; f++) begin
      checks++;
      if (!oks[f] || f >= exp_q.size() || got[f] !== exp_q[f]) begin
        errors++;
        $display("FAIL b2b_byte%0d got %h ok %0d want %h", f, got[f], oks[f],
                 (f < exp_q.size()) ? exp_q[f] : 8'h00);
      end
      if (f > 0) begin
        checks++;
        if (starts[f] - starts[f-1] != FRAME + 1) begin
          errors++;
          $display("FAIL b2b_gap%0d got %0d want %0d", f, starts[f] - starts[f-1], FRAME + 1);
        end
      end
    end
    capture_tx(extra, extra_ok, extra_start, 2 * FRAME);
    checks++;
    if (extra_ok) begin
      errors++;
      $display("FAIL b2b_dropped got frame %h want none", extra);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] rb, tb2, rb2, got;
    bit ok;
    int st;
    apply_reset();
    rb = 8'($urandom);
    write_tx(8'($urandom));
    rx_drive = 1'b0;
    step(CPB);
    for (int i = 0; i < 3; i++) begin
      rx_drive = rb[i];
      step(CPB);
    end
    rx_drive = 1'b1;
    reset    = 1'b1;
    step(1);
    checks++; if (uart_tx_out !== 1'b1)   begin errors++; $display("FAIL midrst_tx got %b want 1", uart_tx_out); end
    checks++; if (cpu_valid_out !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", cpu_valid_out); end
    checks++; if (cpu_ready_out !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", cpu_ready_out); end
    reset = 1'b0;
    step(1);
    tb2 = 8'($urandom);
    rb2 = 8'($urandom);
    fork
      begin
        write_tx(tb2);
        capture_tx(got, ok, st, 3 * FRAME);
        checks++;
        if (!ok || got !== tb2) begin
          errors++;
          $display("FAIL midrst_txbyte got %h ok %0d want %h", got, ok, tb2);
        end
      end
      begin
        send_rx_frame(rb2, 1'b1, CPB);
        check_popped("midrst_rxbyte", rb2);
      end
    join
    checks++; if (cpu_valid_out !== 1'b0) begin errors++; $display("FAIL midrst_leftover got valid %b want 0", cpu_valid_out); end
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_loopback();
    test_rx_latency_random();
    test_overrun();
    test_full_push_pop();
    test_glitch_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
